// File: rtl/mac_requant.sv
// Accumulator-to-feature-map requantizer: 2N-bit Q(2Q) words are rounded half-up,
// saturated to N-bit Q(Q), optionally ReLU-clamped, then buffered in a small output FIFO.
module mac_requant #(
    parameter int unsigned N     = 16,
    parameter int unsigned Q     = 12,
    parameter int unsigned DEPTH = 4
) (
    input  logic           clk,
    input  logic           sclr,
    input  logic           acc_valid_i,
    output logic           acc_ready_o,
    input  logic [2*N-1:0] acc_i,
    input  logic           relu_en_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [N-1:0]   out_o,
    output logic           sat_o,
    input  logic           sat_clr_i,
    output logic [15:0]    sat_cnt_o,
    output logic           busy_o
);

    localparam int unsigned SW = 2 * N + 1;
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [PW+1:0] DepthC = (PW + 2)'(DEPTH);
    localparam logic signed [SW-1:0] RoundC = {{(SW - Q){1'b0}}, 1'b1, {(Q - 1){1'b0}}};
    localparam logic signed [SW-1:0] SatHi  = {{(SW - N + 1){1'b0}}, {(N - 1){1'b1}}};
    localparam logic signed [SW-1:0] SatLo  = {{(SW - N + 1){1'b1}}, {(N - 1){1'b0}}};

    // Stage 1 registers
    logic                 s1_valid_q;
    logic                 s1_relu_q;
    logic signed [SW-1:0] s1_sum_q;

    // FIFO state
    logic [N-1:0]  mem_data_q [DEPTH];
    logic          mem_sat_q  [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic [15:0]   sat_cnt_q, sat_cnt_d;

    logic          accept;
    logic          push;
    logic          pop;
    logic [PW+1:0] occupancy;

    logic signed [SW-1:0] shifted;
    logic [N-1:0]         res;
    logic                 res_sat;

    // Occupancy counts the word in stage 1 so it always has a FIFO slot next edge.
    assign occupancy   = {1'b0, cnt_q} + {{(PW + 1){1'b0}}, s1_valid_q};
    assign acc_ready_o = (occupancy < DepthC);
    assign accept      = acc_valid_i & acc_ready_o;
    assign push        = s1_valid_q;
    assign out_valid_o = (cnt_q != '0);
    assign pop         = out_valid_o & out_ready_i;
    assign busy_o      = s1_valid_q | out_valid_o;
    assign sat_cnt_o   = sat_cnt_q;
    assign out_o       = out_valid_o ? mem_data_q[rd_ptr_q] : '0;
    assign sat_o       = out_valid_o ? mem_sat_q[rd_ptr_q] : 1'b0;

    always_ff @(posedge clk) begin
        if (sclr) begin
            s1_valid_q <= 1'b0;
            s1_relu_q  <= 1'b0;
            s1_sum_q   <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_relu_q <= relu_en_i;
                s1_sum_q  <= {acc_i[2*N-1], acc_i} + RoundC;
            end
        end
    end

    always_comb begin
        shifted = s1_sum_q >>> Q;
        res     = shifted[N-1:0];
        res_sat = 1'b0;
        if (shifted > SatHi) begin
            res     = SatHi[N-1:0];
            res_sat = 1'b1;
        end else if (shifted < SatLo) begin
            res     = SatLo[N-1:0];
            res_sat = 1'b1;
        end
        // ReLU applies after saturation and never affects the sat flag.
        if (s1_relu_q && res[N-1]) begin
            res = '0;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + (PW + 1)'(1);
            2'b01:   cnt_d = cnt_q - (PW + 1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (sat_clr_i) begin
            sat_cnt_d = '0;
        end else if (push && res_sat && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            sat_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    // Storage is not reset; outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!sclr && push) begin
            mem_data_q[wr_ptr_q] <= res;
            mem_sat_q[wr_ptr_q]  <= res_sat;
        end
    end

endmodule

// File: tb/tb_mac_requant.sv
// Bench for mac_requant: a spec-level queue model checked every cycle, plus directed
// vectors with hand-computed results.
module tb_mac_requant;

    localparam int unsigned N     = 16;
    localparam int unsigned Q     = 12;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        sclr = 1'b1;
    logic        acc_valid_i = 1'b0;
    logic        acc_ready_o;
    logic [31:0] acc_i = '0;
    logic        relu_en_i = 1'b0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [15:0] out_o;
    logic        sat_o;
    logic        sat_clr_i = 1'b0;
    logic [15:0] sat_cnt_o;
    logic        busy_o;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    int pops   = 0;

    mac_requant #(.N(N), .Q(Q), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .sclr       (sclr),
        .acc_valid_i(acc_valid_i),
        .acc_ready_o(acc_ready_o),
        .acc_i      (acc_i),
        .relu_en_i  (relu_en_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_o      (out_o),
        .sat_o      (sat_o),
        .sat_clr_i  (sat_clr_i),
        .sat_cnt_o  (sat_cnt_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Requantize from the arithmetic definition: floor((v + 2^(Q-1)) / 2^Q), clip, ReLU.
    function automatic logic [16:0] model(input logic [31:0] a, input logic r);
        longint v;
        longint t;
        longint q;
        logic   s;
        v = longint'($signed(a));
        t = v + 2048;
        q = t / 4096;
        if ((t % 4096 != 0) && (t < 0)) q = q - 1;
        s = 1'b0;
        if (q > 32767) begin
            q = 32767;
            s = 1'b1;
        end else if (q < -32768) begin
            q = -32768;
            s = 1'b1;
        end
        if (r && q < 0) q = 0;
        return {s, q[15:0]};
    endfunction

    // Model state: buffered results, the word in flight, and the saturation count.
    logic [16:0] fq[$];
    bit          s1_has = 1'b0;
    logic [16:0] s1_val = '0;
    int          sc = 0;

    always @(negedge clk) begin
        bit          e_ready;
        bit          e_valid;
        logic [16:0] head;
        e_ready = (fq.size() + int'(s1_has)) < DEPTH;
        e_valid = fq.size() > 0;
        head    = e_valid ? fq[0] : 17'd0;
        if (chk_en) begin
            chk("acc_ready", 32'(acc_ready_o), 32'(e_ready));
            chk("out_valid", 32'(out_valid_o), 32'(e_valid));
            chk("out_data", 32'(out_o), 32'(head[15:0]));
            chk("out_sat", 32'(sat_o), 32'(head[16]));
            chk("sat_cnt", 32'(sat_cnt_o), 32'(sc));
            chk("busy", 32'(busy_o), 32'(s1_has || e_valid));
            chk("fifo_cnt_bound", 32'(dut.cnt_q <= DEPTH), 32'd1);
        end
        if (sclr) begin
            fq.delete();
            s1_has = 1'b0;
            sc = 0;
        end else begin
            if (e_valid && out_ready_i) begin
                void'(fq.pop_front());
                pops++;
            end
            if (s1_has) begin
                fq.push_back(s1_val);
                if (s1_val[16] && sc < 65535) sc++;
            end
            if (sat_clr_i) sc = 0;
            s1_has = acc_valid_i && e_ready;
            s1_val = model(acc_i, relu_en_i);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic r, input logic [15:0] eo,
                        input logic es, input string nm);
        acc_valid_i = 1'b1;
        acc_i       = a;
        relu_en_i   = r;
        step();
        acc_valid_i = 1'b0;
        acc_i       = $urandom;
        relu_en_i   = 1'($urandom);
        step();
        chk({nm, "_out"}, 32'(out_o), 32'(eo));
        chk({nm, "_sat"}, 32'(sat_o), 32'(es));
        step();
    endtask

    logic [31:0] bp_words[6] = '{32'h00100000, 32'h00200000, 32'hFFE00000,
                                 32'h7FFFFFFF, 32'h00000800, 32'h12345678};

    initial begin
        int idx;
        int pops0;
        step();
        step();
        chk("rst_ready", 32'(acc_ready_o), 32'd1);
        chk("rst_valid", 32'(out_valid_o), 32'd0);
        chk("rst_out", 32'(out_o), 32'd0);
        chk("rst_sat", 32'(sat_o), 32'd0);
        chk("rst_cnt", 32'(sat_cnt_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        sclr   = 1'b0;
        chk_en = 1'b1;

        send(32'h01000000, 1'b0, 16'h1000, 1'b0, "one");
        send(32'h00000800, 1'b0, 16'h0001, 1'b0, "rnd_half_up");
        send(32'h000007FF, 1'b0, 16'h0000, 1'b0, "rnd_below_half");
        send(32'hFFFFF800, 1'b0, 16'h0000, 1'b0, "rnd_neg_half");
        send(32'hFFFFF7FF, 1'b0, 16'hFFFF, 1'b0, "rnd_neg_below");
        send(32'h7FFFFFFF, 1'b0, 16'h7FFF, 1'b1, "sat_pos");
        send(32'h80000000, 1'b0, 16'h8000, 1'b1, "sat_neg");
        chk("sat_cnt_two", 32'(sat_cnt_o), 32'd2);

        // Clear coincides with the push of a third saturating word.
        acc_valid_i = 1'b1;
        acc_i       = 32'h7FFFFFFF;
        relu_en_i   = 1'b0;
        step();
        acc_valid_i = 1'b0;
        sat_clr_i   = 1'b1;
        step();
        sat_clr_i   = 1'b0;
        chk("clr_wins_cnt", 32'(sat_cnt_o), 32'd0);
        chk("clr_wins_sat", 32'(sat_o), 32'd1);
        step();

        send(32'hFF000000, 1'b1, 16'h0000, 1'b0, "relu_neg");
        send(32'hFF000000, 1'b0, 16'hF000, 1'b0, "norelu_neg");
        send(32'h90000000, 1'b1, 16'h0000, 1'b1, "relu_sat");
        chk("sat_cnt_relu", 32'(sat_cnt_o), 32'd1);

        // Backpressure: six words offered against a stalled output.
        out_ready_i = 1'b0;
        idx   = 0;
        pops0 = pops;
        repeat (8) begin
            bit take;
            acc_valid_i = (idx < 6);
            acc_i       = bp_words[idx % 6];
            relu_en_i   = 1'b0;
            take        = acc_valid_i && acc_ready_o;
            step();
            if (take) idx++;
        end
        chk("bp_accepted", 32'(idx), 32'd4);
        chk("bp_ready_low", 32'(acc_ready_o), 32'd0);
        out_ready_i = 1'b1;
        for (int c = 0; c < 40 && (idx < 6 || busy_o); c++) begin
            bit take;
            acc_valid_i = (idx < 6);
            acc_i       = bp_words[idx % 6];
            take        = acc_valid_i && acc_ready_o;
            step();
            if (take) idx++;
        end
        acc_valid_i = 1'b0;
        chk("bp_all_in", 32'(idx), 32'd6);
        step();
        chk("bp_all_out", 32'(pops - pops0), 32'd6);

        // Reset with three words buffered and one in stage 1.
        out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            acc_valid_i = 1'b1;
            acc_i       = (i == 0) ? 32'h7FFFFFFF : 32'(i) << 20;
            chk("mid_ready", 32'(acc_ready_o), 32'd1);
            step();
        end
        acc_valid_i = 1'b0;
        sclr = 1'b1;
        step();
        sclr = 1'b0;
        chk("mid_rst_valid", 32'(out_valid_o), 32'd0);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_cnt", 32'(sat_cnt_o), 32'd0);
        out_ready_i = 1'b1;
        send(32'h00003000, 1'b0, 16'h0003, 1'b0, "post_rst");

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mac_requant.md
Name: mac_requant

Overview:
- Consumer end of the MAC accumulator output interface. It accepts 2N-bit signed accumulator words (2Q fraction bits) over a valid/ready handshake.
- Each word is requantized to N-bit Q-format: round-half-up, saturate, optional ReLU.
- Results are buffered in a small output FIFO and delivered downstream over valid/ready.
- Sits between the convolution MAC array and the feature-map write-back path. It also counts saturation events for debug.

Parameters:
- N, 16, output word width in bits; input is 2N bits
- Q, 12, fraction bits of the output format; input carries 2Q fraction bits
- DEPTH, 4, output FIFO entries; power of two, minimum 2

Ports:
- clk  in  1  clock; all logic is rising-edge
- sclr  in  1  synchronous active-high reset
- acc_valid_i  in  1  accumulator word valid
- acc_ready_o  out  1  block can accept an accumulator word
- acc_i  in  2N  signed accumulator word, 2Q fraction bits
- relu_en_i  in  1  apply ReLU to this word; sampled with acc_i
- out_valid_o  out  1  FIFO head valid
- out_ready_i  in  1  downstream accepts head
- out_o  out  N  signed requantized result, Q fraction bits
- sat_o  out  1  head entry was clipped by saturation
- sat_clr_i  in  1  clear saturation counter
- sat_cnt_o  out  16  number of saturated results written; sticks at 0xFFFF
- busy_o  out  1  stage-1 valid OR FIFO non-empty

Behaviour:
- Interface: one clock (clk); reset sclr is synchronous, active-high.
- Reset: on a clk edge with sclr=1, the stage-1 valid, FIFO pointers, count and sat_cnt_o clear.
  - After reset: acc_ready_o=1, out_valid_o=0, out_o=0, sat_o=0, sat_cnt_o=0, busy_o=0.
  - Reset mid-operation discards in-flight and buffered words with no output.
  - sclr has priority over all other inputs.
- Accept: a word is accepted on any edge where acc_valid_i=1 and acc_ready_o=1.
  - acc_i and relu_en_i may change freely when not accepted.
- Stage 1, at the accept edge:
  - register sum = sign_extend(acc_i, 2N+1) + 2^(Q-1);
  - register relu_en_i and s1_valid.
  - The 2N+1-bit width guarantees no wrap for 0x7FFF...F inputs.
- Stage 2 (combinational from stage 1, written into the FIFO on the next edge):
  - shifted = sum >>> Q (arithmetic shift).
  - If shifted > 2^(N-1)-1: result = 2^(N-1)-1, sat=1.
  - If shifted < -2^(N-1): result = -2^(N-1), sat=1.
  - Otherwise: result = shifted[N-1:0], sat=0.
  - Then, if relu and result is negative: result = 0. sat is unchanged, and ReLU clamping alone never sets sat.
- Latency: word accepted at edge k appears at out_valid_o/out_o/sat_o after edge k+1 when the FIFO was empty. Order is preserved.
- Flow control: acc_ready_o = (fifo_count + s1_valid) < DEPTH.
  - It is computed from registers only, with no combinational path from out_ready_i.
  - A pop in the same cycle is not credited until the next cycle.
  - With DEPTH>=4 and out_ready_i held high, throughput is 1 word/cycle.
- FIFO:
  - Pop on any edge with out_valid_o=1 and out_ready_i=1.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
  - out_o/sat_o hold the head entry and are 0 when empty.
  - Overflow is impossible by construction; the bench asserts count never exceeds DEPTH.
- sat_cnt_o:
  - Increments by 1 on each FIFO push with sat=1; holds at 0xFFFF.
  - sat_clr_i=1 forces 0 on the next edge, and clear wins over a simultaneous increment.
- busy_o: registered-state OR, no combinational input dependence.

Test Plan:
- Reset then N=16, Q=12, acc_i=0x01000000, relu=0 -> after 2 edges out_o=0x1000, sat_o=0. acc_ready_o=1 throughout.
- Rounding:
  - 0x00000800 -> 0x0001
  - 0x000007FF -> 0x0000
  - 0xFFFFF800 -> 0x0000
  - 0xFFFFF7FF -> 0xFFFF
- Saturation and counter:
  - 0x7FFFFFFF -> 0x7FFF, sat=1
  - 0x80000000 -> 0x8000, sat=1
  - sat_cnt_o=2 afterwards.
  - Then sat_clr_i pulsed on the same cycle as a third saturating push -> sat_cnt_o=0.
- ReLU: 0xFF000000 with relu=1 -> 0x0000, sat=0; with relu=0 -> 0xF000. 0x90000000 with relu=1 -> 0x0000, sat=1.
- Backpressure:
  - out_ready_i=0 while pushing 6 words -> exactly 4 accepted and acc_ready_o=0 after them.
  - Raising out_ready_i drains in order. The remaining 2 are accepted and total output equals input order. No loss or duplication.
- Reset mid-stream: sclr asserted with 3 words buffered and 1 in stage 1 -> next cycle out_valid_o=0, busy_o=0, sat_cnt_o=0. A following word still outputs with 2-cycle latency.
